// File: rtl/ipa_tx.sv
// rtl/ipa_tx.sv - IPA serial link transmitter with Wishbone slave, 20-bit two-byte frames
// Optional one-word holding register enabled by defining IPA_TX_BUF_EN.
module ipa_tx #(
    parameter int HALF_PERIOD = 4,
    parameter int CNT_W       = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [15:0] dat_i,
    output logic        ack_o,
    output logic [15:0] dat_o,
    output logic        txd_o,
    output logic        txc_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_PERIOD / 2);
    localparam logic [4:0]       BIT_LAST = 5'd19;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        bit_cnt;
    logic [19:0]       sr;

    logic              phase_end;
    logic              frame_end;
    logic              busy;
    logic              req;
    logic              accept;
    logic              slot_free;
    logic              load_en;
    logic              hold_full;
    logic [15:0]       load_word;

    assign phase_end = (state != S_IDLE) && (cnt == CNT_LAST);
    assign frame_end = (state == S_HIGH) && phase_end && (bit_cnt == BIT_LAST);
    assign busy      = (state != S_IDLE);
    assign req       = cyc_i & stb_i & ~ack_o;
    assign accept    = req & we_i & slot_free;

`ifdef IPA_TX_BUF_EN
    logic [15:0] hold;

    // The slot frees in the same cycle the held word moves into the shifter.
    assign load_en   = hold_full & ((state == S_IDLE) | frame_end);
    assign slot_free = ~hold_full | load_en;
    assign load_word = hold;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= dat_i;
            hold_full <= 1'b1;
        end else if (load_en) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign hold_full = 1'b0;
    assign slot_free = (state == S_IDLE) | frame_end;
    assign load_en   = accept;
    assign load_word = dat_i;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_en) state_nxt = S_LOW;
            end
            S_LOW: begin
                if (phase_end) state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (phase_end) state_nxt = (frame_end && !load_en) ? S_IDLE : S_LOW;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '1;
        end else begin
            cnt <= (phase_end || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
            if (state == S_HIGH && phase_end) begin
                bit_cnt <= frame_end ? 5'd0 : bit_cnt + 5'd1;
            end
            // Start bit is already on the wire from load, so the first cell never shifts.
            if (load_en) begin
                sr <= {1'b1, load_word[15:8], 1'b0, 1'b1, load_word[7:0], 1'b0};
            end else if (state == S_LOW && cnt == CNT_MID && bit_cnt != 5'd0) begin
                sr <= {1'b1, sr[19:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= req & (~we_i | slot_free);
            dat_o <= (req & ~we_i) ? {14'b0, hold_full, busy} : 16'h0000;
        end
    end

    assign txd_o = sr[0];
    assign txc_o = (state == S_HIGH);

endmodule
